cdb_arbiter: RTL and testbench

- Shares the single common data bus (CDB) among NUM_FU functional-unit result producers in the Tomasulo core.
- Each FU hands over one completed {tag, data} result through a valid/ready handshake into a private one-entry holding buffer.
- A round-robin arbiter picks one buffered result per cycle and drives it onto the registered CDB. The tagged register file and the reservation stations snoop this bus to clear tags and capture values.

---
 rtl/cdb_arbiter.sv | 148 ++++++++++++++
 tb/tb_cdb_arbiter.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: shares the registered common data bus among NUM_FU result
// producers. Each FU owns a one-entry holding buffer filled via valid/ready;
// one buffered result per cycle is granted and broadcast as {on, tag, data}.
// Optional build macro CDB_FIXED_PRIO_EN: fixed priority (lowest index wins)
// instead of round-robin; the rotating pointer is then removed.
module cdb_arbiter #(
    parameter int NUM_FU = 4,
    parameter int TAG_W  = 8,
    parameter int DATA_W = 32,
    parameter int CDB_W  = 1 + TAG_W + DATA_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic [NUM_FU-1:0]        req_valid,
    output logic [NUM_FU-1:0]        req_ready,
    input  logic [NUM_FU*TAG_W-1:0]  req_tag,
    input  logic [NUM_FU*DATA_W-1:0] req_data,
    output logic [CDB_W-1:0]         cdb,
    output logic [2:0]               cdb_src,
    output logic                     busy,
    output logic                     tag_err
);

    logic [NUM_FU-1:0] buf_valid_q, buf_valid_d;
    logic [TAG_W-1:0]  buf_tag_q  [NUM_FU];
    logic [DATA_W-1:0] buf_data_q [NUM_FU];

    logic [NUM_FU-1:0] grant;
    logic [NUM_FU-1:0] accept;
    logic [NUM_FU-1:0] tag_zero;
    logic              grant_any;
    logic [2:0]        grant_idx;
    logic [TAG_W-1:0]  win_tag;
    logic [DATA_W-1:0] win_data;

    logic [CDB_W-1:0]  cdb_q;
    logic [2:0]        cdb_src_q;
    logic              tag_err_q;

`ifndef CDB_FIXED_PRIO_EN
    logic [2:0]        rr_ptr_q, rr_ptr_d;
`endif

    // Tag 0 means "value ready" and must never be produced by an FU.
    for (genvar gi = 0; gi < NUM_FU; gi++) begin : g_tag_chk
        assign tag_zero[gi] = req_valid[gi] && (req_tag[gi*TAG_W +: TAG_W] == '0);
    end

    // Pick the winning buffer and mux out its payload.
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        win_tag   = '0;
        win_data  = '0;
`ifdef CDB_FIXED_PRIO_EN
        for (int k = 0; k < NUM_FU; k++) begin
            if (!grant_any && buf_valid_q[k]) begin
                grant_any = 1'b1;
                grant[k]  = 1'b1;
                grant_idx = 3'(k);
                win_tag   = buf_tag_q[k];
                win_data  = buf_data_q[k];
            end
        end
`else
        // Scan starting at rr_ptr, wrapping at NUM_FU.
        for (int k = 0; k < NUM_FU; k++) begin
            int idx;
            idx = int'(rr_ptr_q) + k;
            if (idx >= NUM_FU) idx = idx - NUM_FU;
            if (!grant_any && buf_valid_q[idx]) begin
                grant_any   = 1'b1;
                grant[idx]  = 1'b1;
                grant_idx   = 3'(idx);
                win_tag     = buf_tag_q[idx];
                win_data    = buf_data_q[idx];
            end
        end
`endif
    end

`ifndef CDB_FIXED_PRIO_EN
    assign rr_ptr_d = (grant_idx == 3'(NUM_FU - 1)) ? 3'd0 : grant_idx + 3'd1;
`endif

    // A buffer being drained this cycle may be refilled at the same edge.
    assign req_ready   = {NUM_FU{!flush}} & (~buf_valid_q | grant);
    assign accept      = req_valid & req_ready;
    assign buf_valid_d = accept | (buf_valid_q & ~grant);

    // Occupancy, CDB broadcast, rotation pointer and sticky tag error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q <= '0;
            cdb_q       <= '0;
            cdb_src_q   <= '0;
            tag_err_q   <= 1'b0;
`ifndef CDB_FIXED_PRIO_EN
            rr_ptr_q    <= '0;
`endif
        end else begin
            if (|tag_zero) tag_err_q <= 1'b1;
            if (flush) begin
                buf_valid_q <= '0;
                cdb_q       <= '0;
`ifndef CDB_FIXED_PRIO_EN
                rr_ptr_q    <= '0;
`endif
            end else begin
                buf_valid_q <= buf_valid_d;
                if (grant_any) begin
                    cdb_q     <= {1'b1, win_tag, win_data};
                    cdb_src_q <= grant_idx;
`ifndef CDB_FIXED_PRIO_EN
                    rr_ptr_q  <= rr_ptr_d;
`endif
                end else begin
                    cdb_q <= '0;
                end
            end
        end
    end

    // Payload capture; only accepted entries load (accept is 0 during flush).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                buf_tag_q[i]  <= '0;
                buf_data_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    buf_tag_q[i]  <= req_tag[i*TAG_W +: TAG_W];
                    buf_data_q[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign cdb     = cdb_q;
    assign cdb_src = cdb_src_q;
    assign busy    = |buf_valid_q;
    assign tag_err = tag_err_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Testbench for cdb_arbiter: directed table, hand-written corner sequences and
// random traffic, all checked against a behavioural model of the bus rules.
module tb_cdb_arbiter;
    localparam int N  = 4;
    localparam int TW = 8;
    localparam int DW = 32;
    localparam int CW = 1 + TW + DW;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            flush;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*TW-1:0] req_tag;
    logic [N*DW-1:0] req_data;
    logic [CW-1:0]   cdb;
    logic [2:0]      cdb_src;
    logic            busy;
    logic            tag_err;

    cdb_arbiter #(.NUM_FU(N), .TAG_W(TW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_tag(req_tag), .req_data(req_data),
        .cdb(cdb), .cdb_src(cdb_src), .busy(busy), .tag_err(tag_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Behavioural model: one slot per FU plus the last broadcast.
    bit            mv [N];
    logic [TW-1:0] mt [N];
    logic [DW-1:0] md [N];
    int            mrr;
    logic [CW-1:0] mcdb;
    logic [2:0]    msrc;
    bit            mterr;
    logic [N-1:0]  last_ready;

    typedef struct {
        bit              pre_reset;
        logic [N-1:0]    v;
        logic [N*TW-1:0] tags;
        logic [N*DW-1:0] datas;
        logic [N-1:0]    exp_ready;
        logic [CW-1:0]   exp_cdb;
        logic [2:0]      exp_src;
        logic            exp_busy;
    } vec_t;
    vec_t tbl [9];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Which buffered result the bus rules say wins this cycle (-1 if none).
    function automatic int model_pick();
        int base;
`ifdef CDB_FIXED_PRIO_EN
        base = 0;
`else
        base = mrr;
`endif
        for (int k = 0; k < N; k++) begin
            if (mv[(base + k) % N]) return (base + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) mv[i] = 1'b0;
        mrr = 0; mcdb = '0; msrc = '0; mterr = 1'b0;
    endtask

    // One clock cycle: drive, check ready, edge, update model, check outputs.
    task automatic step(input logic [N-1:0] v, input logic [N*TW-1:0] tags,
                        input logic [N*DW-1:0] datas, input logic fl);
        int g;
        logic [N-1:0] exp_r;
        logic busy_m;
        @(negedge clk);
        req_valid = v; req_tag = tags; req_data = datas; flush = fl;
        #1;
        g = model_pick();
        for (int i = 0; i < N; i++) exp_r[i] = !fl && (!mv[i] || g == i);
        chk("req_ready", 64'(req_ready), 64'(exp_r));
        last_ready = req_ready;
        @(posedge clk);
        for (int i = 0; i < N; i++)
            if (v[i] && tags[i*TW +: TW] == '0) mterr = 1'b1;
        if (fl) begin
            for (int i = 0; i < N; i++) mv[i] = 1'b0;
            mcdb = '0; mrr = 0;
        end else begin
            if (g >= 0) begin
                mcdb  = {1'b1, mt[g], md[g]};
                msrc  = 3'(g);
                mv[g] = 1'b0;
                mrr   = (g + 1) % N;
            end else begin
                mcdb = '0;
            end
            for (int i = 0; i < N; i++) begin
                if (v[i] && exp_r[i]) begin
                    mv[i] = 1'b1;
                    mt[i] = tags[i*TW +: TW];
                    md[i] = datas[i*DW +: DW];
                end
            end
        end
        #1;
        busy_m = 1'b0;
        for (int i = 0; i < N; i++) busy_m |= mv[i];
        chk("cdb", 64'(cdb), 64'(mcdb));
        chk("cdb_src", 64'(cdb_src), 64'(msrc));
        chk("busy", 64'(busy), 64'(busy_m));
        chk("tag_err", 64'(tag_err), 64'(mterr));
    endtask

    task automatic idle();
        step('0, '0, '0, 1'b0);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear immediately.
    task automatic do_reset();
        #2;
        rst_n = 1'b0; req_valid = '0; flush = 1'b0;
        #1;
        chk("rst_cdb", 64'(cdb), 64'd0);
        chk("rst_tag_err", 64'(tag_err), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [TW-1:0]   prev_tag;
        bit              have_prev;
        int              cnt0, cnt2;
        bit              first_rdy3, accepted, found, silent;
        logic [N*TW-1:0] rt;
        logic [N*DW-1:0] rd;

        // Single result then four-way contention, expectations written out.
        tbl[0] = '{1'b1, 4'b0010, 32'h0000_0500, {32'h0, 32'h0, 32'hDEADBEEF, 32'h0},
                   4'b1111, '0, 3'd0, 1'b1};
        tbl[1] = '{1'b0, 4'b0000, '0, '0, 4'b1111, {1'b1, 8'h05, 32'hDEADBEEF}, 3'd1, 1'b0};
        tbl[2] = '{1'b0, 4'b0000, '0, '0, 4'b1111, '0, 3'd1, 1'b0};
        tbl[3] = '{1'b1, 4'b1111, 32'h1413_1211,
                   {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000},
                   4'b1111, '0, 3'd0, 1'b1};
        tbl[4] = '{1'b0, 4'b0000, '0, '0, 4'b0001, {1'b1, 8'h11, 32'hC0DE0000}, 3'd0, 1'b1};
        tbl[5] = '{1'b0, 4'b0000, '0, '0, 4'b0011, {1'b1, 8'h12, 32'hC0DE0001}, 3'd1, 1'b1};
        tbl[6] = '{1'b0, 4'b0000, '0, '0, 4'b0111, {1'b1, 8'h13, 32'hC0DE0002}, 3'd2, 1'b1};
        tbl[7] = '{1'b0, 4'b0000, '0, '0, 4'b1111, {1'b1, 8'h14, 32'hC0DE0003}, 3'd3, 1'b0};
        tbl[8] = '{1'b0, 4'b0000, '0, '0, 4'b1111, '0, 3'd3, 1'b0};

        rst_n = 1'b0; flush = 1'b0; req_valid = '0; req_tag = '0; req_data = '0;
        model_reset();
        #12;
        chk("reset_cdb", 64'(cdb), 64'd0);
        chk("reset_src", 64'(cdb_src), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_tag_err", 64'(tag_err), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int t = 0; t < 9; t++) begin
            if (tbl[t].pre_reset) do_reset();
            step(tbl[t].v, tbl[t].tags, tbl[t].datas, 1'b0);
            chk($sformatf("tbl%0d_ready", t), 64'(last_ready), 64'(tbl[t].exp_ready));
            chk($sformatf("tbl%0d_cdb", t), 64'(cdb), 64'(tbl[t].exp_cdb));
            chk($sformatf("tbl%0d_src", t), 64'(cdb_src), 64'(tbl[t].exp_src));
            chk($sformatf("tbl%0d_busy", t), 64'(busy), 64'(tbl[t].exp_busy));
        end

        // Rotation: FU0 and FU2 re-offer every cycle; bus must alternate.
        do_reset();
        have_prev = 1'b0; cnt0 = 0; cnt2 = 0;
        for (int c = 0; c < 10; c++) begin
            step(4'b0101, 32'h0022_0020, {32'h0, 32'h2222, 32'h0, 32'h2020}, 1'b0);
            if (c > 0) chk("rr_on", 64'(cdb[CW-1]), 64'd1);
            if (cdb[CW-1]) begin
                if (cdb[CW-2 -: TW] == 8'h20) cnt0++;
                if (cdb[CW-2 -: TW] == 8'h22) cnt2++;
                if (have_prev) chk("rr_alternate", 64'(cdb[CW-2 -: TW] != prev_tag), 64'd1);
                prev_tag = cdb[CW-2 -: TW];
                have_prev = 1'b1;
            end
        end
`ifndef CDB_FIXED_PRIO_EN
        chk("rr_nostarve", 64'(cnt0 >= 4 && cnt2 >= 4), 64'd1);
`endif
        repeat (3) idle();

        // Backpressure: FU3 waits behind three others, then re-offers.
        do_reset();
        step(4'b1111, 32'h3332_3130, {32'h3333, 32'h3232, 32'h3131, 32'h3030}, 1'b0);
        accepted = 1'b0; first_rdy3 = 1'b1;
        for (int c = 0; c < 8 && !accepted; c++) begin
            step(4'b1000, 32'h3F00_0000, {32'hB0B0, 96'h0}, 1'b0);
            if (c == 0) first_rdy3 = last_ready[3];
            if (last_ready[3]) accepted = 1'b1;
        end
        chk("bp_ready_low", 64'(first_rdy3), 64'd0);
        chk("bp_accepted", 64'(accepted), 64'd1);
        found = 1'b0;
        for (int c = 0; c < N && !found; c++) begin
            idle();
            if (cdb[CW-1] && cdb[CW-2 -: TW] == 8'h3F) found = 1'b1;
        end
        chk("bp_broadcast", 64'(found), 64'd1);
        repeat (2) idle();

        // Flush with three buffers full: nothing buffered may ever appear.
        do_reset();
        step(4'b0111, 32'h0042_4140, {32'h0, 32'h4242, 32'h4141, 32'h4040}, 1'b0);
        step('0, '0, '0, 1'b1);
        chk("flush_busy", 64'(busy), 64'd0);
        chk("flush_cdb", 64'(cdb), 64'd0);
        silent = 1'b1;
        repeat (3) begin
            idle();
            if (cdb[CW-1]) silent = 1'b0;
        end
        chk("flush_silent", 64'(silent), 64'd1);
        step(4'b0010, 32'h0000_4500, {32'h0, 32'h0, 32'h4545, 32'h0}, 1'b0);
        idle();
        chk("flush_after", 64'(cdb), 64'({1'b1, 8'h45, 32'h4545}));

        // Tag 0 sets the sticky error and is still broadcast.
        step(4'b0100, 32'h0, {32'h0, 32'hCAFE, 32'h0, 32'h0}, 1'b0);
        chk("tagerr_set", 64'(tag_err), 64'd1);
        idle();
        chk("tagerr_bcast", 64'(cdb), 64'({1'b1, 8'h00, 32'hCAFE}));
        chk("tagerr_src", 64'(cdb_src), 64'd2);
        idle();
        chk("tagerr_sticky", 64'(tag_err), 64'd1);
        step(4'b0100, 32'h0, {32'h0, 32'hBEEF, 32'h0, 32'h0}, 1'b0);
        idle();
        do_reset();

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                rt[i*TW +: TW] = 8'($urandom_range(1, 255));
                rd[i*DW +: DW] = $urandom;
            end
            step(N'($urandom), rt, rd, ($urandom_range(0, 15) == 0));
        end
        repeat (N + 1) idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
